// File: rtl/instr_sequencer.sv
// instr_sequencer: multicycle control FSM for the 9-bit miniMips core.
// Fetches from the instruction ROM and holds the word for the decoder.
// Sequences FETCH -> DECODE -> EXEC -> (MEM) -> WB and updates the PC.
// Drives the data-memory handshake and the register-file write strobe.
// Optional build macro SEQ_PERF_CNT_EN adds saturating cycle/instruction
// counters on the cycle_cnt / instr_cnt ports.
module instr_sequencer #(
    parameter int PC_W        = 10,
    parameter int START_ADDR  = 0,
    parameter int PROG_END    = 1023,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [8:0]      instr_in,
    input  logic            dec_write_en,
    input  logic            dec_mem_read,
    input  logic            dec_mem_write,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    input  logic            mem_ready,
    output logic [PC_W-1:0] pc,
    output logic [8:0]      instr_q,
    output logic            reg_we,
    output logic            mem_req,
    output logic            mem_we,
    output logic            busy,
    output logic            done,
    output logic            mem_err
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [15:0]     cycle_cnt,
    output logic [15:0]     instr_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_e;

    // The wait counter only ever reaches MEM_TIMEOUT-1.
    localparam int                CNT_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);
    localparam logic [PC_W-1:0]   PC_START = PC_W'(START_ADDR);
    localparam logic [PC_W-1:0]   PC_LAST  = PC_W'(PROG_END);

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [8:0]        instr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              br_q, br_d;
    logic [PC_W-1:0]   tgt_q, tgt_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    // State and datapath registers.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= PC_START;
            instr_q <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            tgt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            tgt_q   <= tgt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic plus the Moore-style strobes decoded from the state.
    // NOTE: every signal written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        tgt_d   = tgt_q;
        done_d  = done_q;
        err_d   = err_q;
        reg_we  = 1'b0;
        mem_req = 1'b0;
        mem_we  = 1'b0;
        busy    = 1'b1;

        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    pc_d    = PC_START;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                instr_d = instr_in;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                state_d = S_EXEC;
            end
            S_EXEC: begin
                // Branch inputs are only trusted here; capture them for WB.
                br_d  = branch_taken;
                tgt_d = branch_target;
                if (dec_mem_read || dec_mem_write) begin
                    cnt_d   = '0;
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = dec_mem_write;
                if (mem_ready) begin
                    state_d = S_WB;
                end else if (cnt_q == CNT_LAST) begin
                    // Abort without write-back; pc stays on the faulting op.
                    err_d   = 1'b1;
                    state_d = S_HALT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WB: begin
                reg_we = dec_write_en;
                if (pc_q == PC_LAST) begin
                    done_d  = 1'b1;
                    state_d = S_HALT;
                end else begin
                    pc_d    = br_q ? tgt_q : pc_q + 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_HALT: begin
                busy = 1'b0;
                if (start) begin
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    pc_d    = PC_START;
                    state_d = S_FETCH;
                end
            end
            default: begin
                busy    = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign pc      = pc_q;
    assign done    = done_q;
    assign mem_err = err_q;

`ifdef SEQ_PERF_CNT_EN
    logic        start_ok;
    logic        in_wb;
    logic [15:0] cyc_q, cyc_d;
    logic [15:0] ins_q, ins_d;

    assign start_ok = start && (state_q == S_IDLE || state_q == S_HALT);
    assign in_wb    = (state_q == S_WB);

    // Saturating counters; busy is low in HALT so they hold there.
    always_comb begin
        cyc_d = cyc_q;
        ins_d = ins_q;
        if (start_ok) begin
            cyc_d = '0;
            ins_d = '0;
        end else begin
            if (busy && cyc_q != 16'hFFFF) cyc_d = cyc_q + 1'b1;
            if (in_wb && ins_q != 16'hFFFF) ins_d = ins_q + 1'b1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc_q <= '0;
            ins_q <= '0;
        end else begin
            cyc_q <= cyc_d;
            ins_q <= ins_d;
        end
    end

    assign cycle_cnt = cyc_q;
    assign instr_cnt = ins_q;
`else
    // Counters not built: no extra ports or state.
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer (PC_W=4, START_ADDR=0, PROG_END=2).
// Each instruction pushes its expected outcome to a scoreboard queue; the
// observed outcome is collected cycle by cycle and compared on pop.
module tb_instr_sequencer;

    localparam int PC_W        = 4;
    localparam int START_ADDR  = 0;
    localparam int PROG_END    = 2;
    localparam int MEM_TIMEOUT = 15;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [8:0]      instr_in;
    logic            dec_write_en;
    logic            dec_mem_read;
    logic            dec_mem_write;
    logic            branch_taken;
    logic [PC_W-1:0] branch_target;
    logic            mem_ready;
    logic [PC_W-1:0] pc;
    logic [8:0]      instr_q;
    logic            reg_we;
    logic            mem_req;
    logic            mem_we;
    logic            busy;
    logic            done;
    logic            mem_err;
`ifdef SEQ_PERF_CNT_EN
    logic [15:0]     cycle_cnt;
    logic [15:0]     instr_cnt;
`endif

    instr_sequencer #(
        .PC_W       (PC_W),
        .START_ADDR (START_ADDR),
        .PROG_END   (PROG_END),
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .instr_in     (instr_in),
        .dec_write_en (dec_write_en),
        .dec_mem_read (dec_mem_read),
        .dec_mem_write(dec_mem_write),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .mem_ready    (mem_ready),
        .pc           (pc),
        .instr_q      (instr_q),
        .reg_we       (reg_we),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .busy         (busy),
        .done         (done),
        .mem_err      (mem_err)
`ifdef SEQ_PERF_CNT_EN
        ,
        .cycle_cnt    (cycle_cnt),
        .instr_cnt    (instr_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [PC_W-1:0] pc;
        logic [8:0]      instr;
        int unsigned     reg_we_cnt;
        int unsigned     mem_cycles;
        int unsigned     lat;
        logic [PC_W-1:0] next_pc;
        logic            done;
        logic            err;
    } rec_t;

    rec_t            sb_q[$];
    logic [PC_W-1:0] model_pc;
    int unsigned     exp_cycles;
    int unsigned     exp_instrs;

    // Accepted start from IDLE/HALT; returns at the negedge in FETCH.
    task automatic do_start();
        check("pre_start_idle", busy, 1'b0);
        start      = 1'b1;
        model_pc   = PC_W'(START_ADDR);
        exp_cycles = 0;
        exp_instrs = 0;
        @(negedge clk);
        start = 1'b0;
        check("start_busy", busy, 1'b1);
        check("start_clr_done", done, 1'b0);
        check("start_clr_err", mem_err, 1'b0);
    endtask

    // Execute one instruction; enter and leave at a negedge.
    // waits < 0 means mem_ready never rises.
    task automatic run_instr(input logic we, input logic rd, input logic wr,
                             input logic taken, input logic [PC_W-1:0] tgt,
                             input int waits, input bit poke_start);
        rec_t e;
        rec_t got;
        bit   is_mem;
        bit   tmo;
        int   guard;

        is_mem = rd || wr;
        tmo    = is_mem && (waits < 0 || waits >= MEM_TIMEOUT);
        e.pc         = model_pc;
        e.instr      = 9'($urandom_range(1, 511));
        e.mem_cycles = !is_mem ? 0 : (tmo ? MEM_TIMEOUT : waits + 1);
        e.reg_we_cnt = (we && !tmo) ? 1 : 0;
        e.lat        = !is_mem ? 4 : (tmo ? 3 + MEM_TIMEOUT : 5 + waits);
        e.done       = !tmo && (model_pc == PC_W'(PROG_END));
        e.err        = tmo;
        e.next_pc    = (tmo || e.done) ? model_pc : (taken ? tgt : model_pc + 1'b1);
        sb_q.push_back(e);
        model_pc   = e.next_pc;
        exp_cycles += e.lat;
        if (!tmo) exp_instrs++;

        got.reg_we_cnt = 0;
        got.mem_cycles = 0;
        got.lat        = 0;

        // FETCH: present the ROM word; mem_ready/branch are noise here.
        got.pc        = pc;
        instr_in      = e.instr;
        branch_taken  = 1'($urandom);
        branch_target = PC_W'($urandom);
        mem_ready     = 1'b1;
        got.reg_we_cnt += reg_we;
        got.lat        += busy;
        @(negedge clk);
        // DECODE: decoder flags follow the latched word.
        got.instr     = instr_q;
        instr_in      = 9'($urandom);
        dec_write_en  = we;
        dec_mem_read  = rd;
        dec_mem_write = wr;
        got.reg_we_cnt += reg_we;
        got.lat        += busy;
        @(negedge clk);
        // EXEC: real branch inputs.
        branch_taken  = taken;
        branch_target = tgt;
        mem_ready     = 1'b0;
        if (poke_start) start = 1'b1;
        got.reg_we_cnt += reg_we;
        got.lat        += busy;
        @(negedge clk);
        start         = 1'b0;
        branch_taken  = ~taken;
        branch_target = ~tgt;
        guard = 0;
        while (mem_req === 1'b1 && guard < 40) begin
            check("mem_we", mem_we, wr);
            mem_ready = (waits >= 0) && (int'(got.mem_cycles) == waits);
            got.mem_cycles++;
            got.reg_we_cnt += reg_we;
            got.lat        += busy;
            guard++;
            @(negedge clk);
        end
        mem_ready = 1'b0;
        if (busy) begin
            got.reg_we_cnt += reg_we;
            got.lat        += busy;
            @(negedge clk);
        end
        got.next_pc = pc;
        got.done    = done;
        got.err     = mem_err;

        e = sb_q.pop_front();
        check("fetch_pc", got.pc, e.pc);
        check("instr_q", got.instr, e.instr);
        check("reg_we_pulses", got.reg_we_cnt, e.reg_we_cnt);
        check("mem_cycles", got.mem_cycles, e.mem_cycles);
        check("latency", got.lat, e.lat);
        check("next_pc", got.next_pc, e.next_pc);
        check("done", got.done, e.done);
        check("mem_err", got.err, e.err);
    endtask

    // Halted: flags and pc hold; ignored inputs stay ignored.
    task automatic check_halt(input logic exp_done, input logic exp_err);
        for (int i = 0; i < 3; i++) begin
            check("halt_busy", busy, 1'b0);
            check("halt_pc", pc, model_pc);
            check("halt_done", done, exp_done);
            check("halt_err", mem_err, exp_err);
            check("halt_req", mem_req, 1'b0);
            check("halt_we", reg_we, 1'b0);
            mem_ready     = 1'b1;
            branch_taken  = 1'($urandom);
            branch_target = PC_W'($urandom);
            @(negedge clk);
        end
        mem_ready = 1'b0;
`ifdef SEQ_PERF_CNT_EN
        check("cycle_cnt", cycle_cnt, exp_cycles);
        check("instr_cnt", instr_cnt, exp_instrs);
`endif
    endtask

    // Three ALU instructions at 0,1,2 ending in a normal halt.
    task automatic run_alu_prog();
        do_start();
        run_instr(1, 0, 0, 0, 4'd0, 0, 0);
        run_instr(1, 0, 0, 0, 4'd0, 0, 0);
        run_instr(1, 0, 0, 0, 4'd0, 0, 0);
        check_halt(1'b1, 1'b0);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; instr_in = '0;
        dec_write_en = 1'b0; dec_mem_read = 1'b0; dec_mem_write = 1'b0;
        branch_taken = 1'b0; branch_target = '0; mem_ready = 1'b0;
        model_pc = '0; exp_cycles = 0; exp_instrs = 0;
        #2 reset = 1'b1;
        @(negedge clk);
        check("rst_pc", pc, START_ADDR);
        check("rst_instr", instr_q, 9'd0);
        check("rst_reg_we", reg_we, 1'b0);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", mem_err, 1'b0);
        reset = 1'b0;
        // IDLE without start stays put.
        repeat (3) @(negedge clk);
        check("idle_busy", busy, 1'b0);
        check("idle_pc", pc, START_ADDR);

        // Run 1: straight-line program to PROG_END.
        run_alu_prog();

        // Run 2: branches, memory waits, spin, wrap, then timeout abort.
        do_start();
        run_instr(0, 0, 0, 1, 4'd5, 0, 0);   // 0 -> 5
        run_instr(1, 1, 0, 0, 4'd0, 3, 0);   // load, 3 waits
        run_instr(1, 0, 0, 0, 4'd0, 0, 1);   // start poked in EXEC
        run_instr(0, 0, 0, 1, 4'd3, 0, 0);   // 7 -> 3
        run_instr(0, 0, 0, 1, 4'd3, 0, 0);   // spin at 3
        run_instr(0, 0, 0, 0, 4'd9, 0, 0);   // not taken -> 4
        run_instr(0, 0, 0, 1, 4'd7, 0, 0);   // 4 -> 7
        run_instr(0, 0, 0, 0, 4'd3, 0, 0);   // 7 not taken -> 8
        run_instr(0, 0, 1, 0, 4'd0, 0, 0);   // store, immediate ready
        run_instr(1, 1, 1, 0, 4'd0, 1, 0);   // both flags: store wins
        run_instr(0, 0, 0, 1, 4'd15, 0, 0);  // 10 -> 15
        run_instr(1, 0, 0, 0, 4'd0, 0, 0);   // 15 wraps to 0
        run_instr(1, 0, 1, 0, 4'd0, -1, 0);  // store never ready
        check_halt(1'b0, 1'b1);

        // Run 3: restart after the abort.
        run_alu_prog();

        // Run 4: reset in the middle of a memory access.
        do_start();
        run_instr(0, 0, 0, 1, 4'd5, 0, 0);   // 0 -> 5
        instr_in = 9'h0AB;
        @(negedge clk);
        dec_write_en = 1'b1; dec_mem_read = 1'b1; dec_mem_write = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_mem_req", mem_req, 1'b1);
        @(negedge clk);
        check("mid_mem_req2", mem_req, 1'b1);
        reset = 1'b1;
        #1;
        check("rstmem_req", mem_req, 1'b0);
        check("rstmem_busy", busy, 1'b0);
        check("rstmem_pc", pc, START_ADDR);
        check("rstmem_instr", instr_q, 9'd0);
        check("rstmem_reg_we", reg_we, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_busy", busy, 1'b0);
        check("post_rst_req", mem_req, 1'b0);
        check("post_rst_pc", pc, START_ADDR);
        check("post_rst_done", done, 1'b0);
`ifdef SEQ_PERF_CNT_EN
        check("post_rst_cyc", cycle_cnt, 0);
        check("post_rst_ins", instr_cnt, 0);
`endif
        check("sb_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
